// File: rtl/quat_pkg.sv
// Shared constants and reader FSM encoding for the quaternion FIFO reader.
package quat_pkg;

  localparam int DATA_W = 16;  // one quaternion component lane
  localparam int LANES  = 8;   // A = lanes 0-3 (w,x,y,z), B = lanes 4-7
  localparam int CNT_W  = 16;  // width of the transfer counter

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_REQ     = 2'd1,
    RD_CAPTURE = 2'd2
  } rd_state_e;

  // Buffer occupancy as it will be once a same-cycle pop has retired.
  function automatic logic [1:0] occ_after_pop(input logic [1:0] occ, input logic pop);
    return occ - {1'b0, pop};
  endfunction

endpackage

// File: rtl/quat_skid_buf.sv
// Two-entry in-order queue holding captured quaternion pairs.
// Head is entry head_q; a second entry waits in tail_q.
module quat_skid_buf #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [LANES-1:0][DATA_W-1:0]  push_data_i,
  input  logic                          pop_i,
  output logic                          valid_o,
  output logic [LANES-1:0][DATA_W-1:0]  head_o,
  output logic [1:0]                    occ_o
);

  logic [1:0]                   occ_q, occ_d;
  logic [LANES-1:0][DATA_W-1:0] head_q, head_d;
  logic [LANES-1:0][DATA_W-1:0] tail_q, tail_d;
  logic                         pop, push;

  // Pops only count while something is held; pushes are dropped if full
  // without a same-cycle pop (the reader never lets that happen).
  assign pop  = pop_i & (occ_q != 2'd0);
  assign push = push_i & ((occ_q != 2'd2) | pop);

  // Next-state of the queue: shift on pop, fill the first free slot on push.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data_i;
        else               tail_d = push_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; new entry lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Queue state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign head_o  = head_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/quat_fifo_reader.sv
// Pulls quaternion pairs from an upstream registered FIFO into a 2-entry
// buffer and presents them on a valid/ready port. One read is in flight at a
// time and reads are spaced by at least 3 cycles so the lagging empty flag
// can never cause an underflow. The lane ports fix the entry at 8 lanes.
module quat_fifo_reader import quat_pkg::*; #(
  parameter int DATA_W = quat_pkg::DATA_W,
  parameter int LANES  = quat_pkg::LANES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_q0,
  input  logic [DATA_W-1:0] fifo_q1,
  input  logic [DATA_W-1:0] fifo_q2,
  input  logic [DATA_W-1:0] fifo_q3,
  input  logic [DATA_W-1:0] fifo_q4,
  input  logic [DATA_W-1:0] fifo_q5,
  input  logic [DATA_W-1:0] fifo_q6,
  input  logic [DATA_W-1:0] fifo_q7,
  output logic              fifo_read_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_q0,
  output logic [DATA_W-1:0] m_q1,
  output logic [DATA_W-1:0] m_q2,
  output logic [DATA_W-1:0] m_q3,
  output logic [DATA_W-1:0] m_q4,
  output logic [DATA_W-1:0] m_q5,
  output logic [DATA_W-1:0] m_q6,
  output logic [DATA_W-1:0] m_q7,
  output logic [CNT_W-1:0]  pair_count,
  output logic              busy
);

  rd_state_e                    state_q, state_d;
  logic [LANES-1:0][DATA_W-1:0] fifo_vec, head_vec;
  logic [1:0]                   occ;
  logic                         buf_valid, pop, push, read_en;
  logic [CNT_W-1:0]             pair_cnt_q, pair_cnt_d;

  assign fifo_vec = {fifo_q7, fifo_q6, fifo_q5, fifo_q4,
                     fifo_q3, fifo_q2, fifo_q1, fifo_q0};

  assign pop = buf_valid & m_ready;

  quat_skid_buf #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (fifo_vec),
    .pop_i       (m_ready),
    .valid_o     (buf_valid),
    .head_o      (head_vec),
    .occ_o       (occ)
  );

  // Read sequencer: IDLE decides, REQ strobes, CAPTURE takes the data.
  // Space is reserved at IDLE time, so a capture always finds a free slot.
  always_comb begin
    state_d = state_q;
    read_en = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (enable && !fifo_empty && (occ_after_pop(occ, pop) < 2'd2))
          state_d = RD_REQ;
      end
      RD_REQ: begin
        read_en = 1'b1;
        state_d = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        push    = 1'b1;
        state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RD_IDLE;
    else       state_q <= state_d;
  end

  // Completed-transfer counter, free-running modulo 2^CNT_W.
  always_comb begin
    pair_cnt_d = pair_cnt_q + {{(CNT_W-1){1'b0}}, pop};
  end

  // Transfer counter register.
  always_ff @(posedge clk) begin
    if (reset) pair_cnt_q <= '0;
    else       pair_cnt_q <= pair_cnt_d;
  end

  assign fifo_read_en = read_en;
  assign m_valid      = buf_valid;
  assign pair_count   = pair_cnt_q;
  assign busy         = (state_q != RD_IDLE) | (occ != 2'd0);

  assign m_q0 = head_vec[0];
  assign m_q1 = head_vec[1];
  assign m_q2 = head_vec[2];
  assign m_q3 = head_vec[3];
  assign m_q4 = head_vec[4];
  assign m_q5 = head_vec[5];
  assign m_q6 = head_vec[6];
  assign m_q7 = head_vec[7];

endmodule

// File: tb/tb_quat_fifo_reader.sv
// Bench for quat_fifo_reader: a cycle table for the basic timing, directed
// corner sequences, and a randomized run against a queue-level model of the
// upstream FIFO and of the delivered stream.
module tb_quat_fifo_reader;

  typedef logic [7:0][15:0] ent_t;
  typedef struct {
    bit          en, emp, rdy;
    bit          rd, mv, bz, dchk;
    logic [15:0] pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, enable, fifo_empty, m_ready;
  ent_t        fq, mq;
  logic        fifo_read_en, m_valid, busy;
  logic [15:0] pair_count;

  always #5 clk = ~clk;

  quat_fifo_reader #(.DATA_W(16), .LANES(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_q0(fq[0]), .fifo_q1(fq[1]), .fifo_q2(fq[2]), .fifo_q3(fq[3]),
    .fifo_q4(fq[4]), .fifo_q5(fq[5]), .fifo_q6(fq[6]), .fifo_q7(fq[7]),
    .fifo_read_en(fifo_read_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_q0(mq[0]), .m_q1(mq[1]), .m_q2(mq[2]), .m_q3(mq[3]),
    .m_q4(mq[4]), .m_q5(mq[5]), .m_q6(mq[6]), .m_q7(mq[7]),
    .pair_count(pair_count), .busy(busy)
  );

  int          compared = 0, mismatched = 0;
  ent_t        up_q[$], exp_q[$];   // upstream FIFO contents / read-not-yet-delivered
  bit          auto_fifo = 1'b0, rd_prev = 1'b0, emp_prev = 1'b0, hold_prev = 1'b0;
  ent_t        head_prev, k_ent;
  logic [15:0] pc_exp;
  vec_t        tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ent(input string nm, input ent_t act, input ent_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    for (int i = 0; i < 8; i++) e[i] = 16'($urandom);
    return e;
  endfunction

  // One clock: protocol checks before the edge, upstream FIFO model after it.
  task automatic step();
    bit rd, pop, emp_now;
    int sz_before;
    rd = fifo_read_en; emp_now = fifo_empty; pop = m_valid & m_ready;
    chk("read_back_to_back", 32'(rd & rd_prev), 32'd0);
    chk("read_after_empty", 32'(rd & emp_prev), 32'd0);
    if (hold_prev) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk_ent("hold_head", mq, head_prev);
    end
    if (auto_fifo) begin
      chk("m_valid", 32'(m_valid), 32'((exp_q.size() - int'(rd_prev)) != 0));
      chk("busy", 32'(busy), 32'(rd | (exp_q.size() != 0)));
      if (pop) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL pop_unexpected: got transfer, expected none");
        end else begin
          k_ent = exp_q.pop_front();
          compared--;
          chk_ent("m_q_order", mq, k_ent);
        end
        pc_exp++;
      end
    end
    hold_prev = m_valid & ~m_ready;
    head_prev = mq;
    @(posedge clk); #1;
    if (auto_fifo) begin
      sz_before = up_q.size();
      if (rd) begin
        chk("fifo_underflow", 32'(up_q.size() != 0), 32'd1);
        if (up_q.size() != 0) begin
          fq = up_q.pop_front();
          exp_q.push_back(fq);
        end
      end
      fifo_empty = (sz_before == 0);
      chk("buffer_bound", 32'(exp_q.size() <= 2), 32'd1);
      if (pop) chk("pair_count", 32'(pair_count), 32'(pc_exp));
    end
    rd_prev = rd; emp_prev = emp_now;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    up_q.delete(); exp_q.delete();
    rd_prev = 1'b0; emp_prev = 1'b0; hold_prev = 1'b0; pc_exp = 16'd0;
    if (auto_fifo) fifo_empty = 1'b1;
  endtask

  task automatic drain(input string nm);
    enable = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 300 && (up_q.size() != 0 || exp_q.size() != 0 || busy); k++) step();
    chk({nm, "_drained"}, 32'(up_q.size() + exp_q.size() + int'(busy)), 32'd0);
  endtask

  initial begin
    int nrd;
    ent_t ref_ent;
    reset = 1'b1; enable = 1'b0; fifo_empty = 1'b1; m_ready = 1'b0; fq = '0;
    for (int i = 0; i < 8; i++) ref_ent[i] = 16'(i + 1);

    // en emp rdy | rd mv busy dchk pc
    tbl[0]  = '{1,0,1, 0,0,0,0, 16'd0};
    tbl[1]  = '{1,0,1, 1,0,1,0, 16'd0};
    tbl[2]  = '{1,1,1, 0,0,1,0, 16'd0};
    tbl[3]  = '{1,1,1, 0,1,1,1, 16'd0};
    tbl[4]  = '{1,1,1, 0,0,0,0, 16'd1};
    tbl[5]  = '{1,0,1, 0,0,0,0, 16'd1};
    tbl[6]  = '{0,0,1, 1,0,1,0, 16'd1};
    tbl[7]  = '{0,0,1, 0,0,1,0, 16'd1};
    tbl[8]  = '{0,0,1, 0,1,1,1, 16'd1};
    tbl[9]  = '{0,0,1, 0,0,0,0, 16'd2};
    tbl[10] = '{0,0,1, 0,0,0,0, 16'd2};
    tbl[11] = '{1,0,1, 0,0,0,0, 16'd2};
    tbl[12] = '{1,1,1, 1,0,1,0, 16'd2};
    tbl[13] = '{1,1,1, 0,0,1,0, 16'd2};
    tbl[14] = '{1,1,1, 0,1,1,1, 16'd2};
    tbl[15] = '{1,1,1, 0,0,0,0, 16'd3};

    // First-entry latency, enable dropped during REQ, reset outputs.
    fq = ref_ent;
    do_reset();
    chk_ent("reset_m_q", mq, '0);
    for (int i = 0; i < 16; i++) begin
      enable = tbl[i].en; fifo_empty = tbl[i].emp; m_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d.read_en", i), 32'(fifo_read_en), 32'(tbl[i].rd));
      chk($sformatf("v%0d.m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("v%0d.pair_count", i), 32'(pair_count), 32'(tbl[i].pc));
      if (tbl[i].dchk) chk_ent($sformatf("v%0d.m_q", i), mq, ref_ent);
      step();
    end

    // Reset while capturing with one entry already buffered.
    enable = 1'b1; fifo_empty = 1'b0; m_ready = 1'b0; nrd = 0;
    for (int k = 0; k < 20 && nrd < 2; k++) begin
      if (fifo_read_en) nrd++;
      step();
    end
    chk("rst_cap.reads", 32'(nrd), 32'd2);
    chk("rst_cap.pre_valid", 32'(m_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("rst_cap.m_valid", 32'(m_valid), 32'd0);
    chk("rst_cap.pair_count", 32'(pair_count), 32'd0);
    chk("rst_cap.read_en", 32'(fifo_read_en), 32'd0);
    chk("rst_cap.busy", 32'(busy), 32'd0);
    chk_ent("rst_cap.m_q", mq, '0);

    // Empty flag toggling every cycle, downstream always ready.
    do_reset();
    enable = 1'b1; m_ready = 1'b1; nrd = 0;
    for (int k = 0; k < 40; k++) begin
      fifo_empty = (k % 2) != 0;
      fq = rand_ent();
      #1;
      if (fifo_read_en) nrd++;
      step();
    end
    chk("toggle.reads", 32'(nrd), 32'd10);

    // Four entries queued, downstream stalled, then released.
    auto_fifo = 1'b1;
    enable = 1'b0; m_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) up_q.push_back(rand_ent());
    k_ent = up_q[0];
    enable = 1'b1; nrd = 0;
    for (int k = 0; k < 20; k++) begin
      if (fifo_read_en) nrd++;
      step();
    end
    chk("stall.reads", 32'(nrd), 32'd2);
    chk("stall.m_valid", 32'(m_valid), 32'd1);
    chk_ent("stall.head", mq, k_ent);
    m_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (fifo_read_en) nrd++;
      step();
    end
    chk("stall.total_reads", 32'(nrd), 32'd4);
    chk("stall.pair_count", 32'(pair_count), 32'd4);
    chk("stall.left", 32'(up_q.size() + exp_q.size()), 32'd0);

    // Randomized traffic against the queue model.
    for (int k = 0; k < 3000; k++) begin
      enable  = ($urandom % 8) != 0;
      m_ready = ($urandom % 3) != 0;
      step();
      if (($urandom % 3) == 0 && up_q.size() < 6) up_q.push_back(rand_ent());
    end
    drain("random");

    // Counter wrap: preset near the top, then a few transfers.
    enable = 1'b0; m_ready = 1'b0;
    step();
    force dut.pair_cnt_q = 16'hFFFD;
    #1 release dut.pair_cnt_q;
    pc_exp = 16'hFFFD;
    step();
    chk("wrap.preset", 32'(pair_count), 32'hFFFD);
    for (int k = 0; k < 4; k++) up_q.push_back(rand_ent());
    drain("wrap");
    chk("wrap.final", 32'(pair_count), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/quat_fifo_reader.md
QUAT_FIFO_READER -- requirements
Module: quat_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of one quaternion component lane.
REQ-002 SHALL have parameter LANES, default 8, lanes per entry (operand A = lanes 0-3 w,x,y,z; operand B = lanes 4-7).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  permits issuing new FIFO reads; reads already in flight always complete.
REQ-006 fifo_empty  input  1  empty flag of the upstream quaternion FIFO; registered, lags FIFO occupancy by one cycle.
REQ-007 fifo_q0..fifo_q7  input  DATA_W each  FIFO registered read data; valid in the cycle after a read strobe.
REQ-008 fifo_read_en  output  1  single-cycle read strobe to the FIFO.
REQ-009 m_valid  output  1  downstream entry available.
REQ-010 m_ready  input  1  downstream accepts entry.
REQ-011 m_q0..m_q7  output  DATA_W each  head entry lanes.
REQ-012 pair_count  output  16  count of completed downstream transfers.
REQ-013 busy  output  1  high when a read is in flight or the buffer is non-empty.

Function
REQ-014 SHALL implement FSM with states IDLE, REQ, CAPTURE.
REQ-015 IDLE->REQ when enable=1, fifo_empty=0 and buffer occupancy <2, evaluated with occupancy after any same-cycle pop; otherwise stay IDLE.
REQ-016 fifo_read_en SHALL be 1 exactly during REQ; REQ->CAPTURE unconditionally.
REQ-017 In CAPTURE, fifo_q0..7 SHALL be written into the buffer tail at the cycle end; CAPTURE->IDLE unconditionally.
REQ-018 fifo_read_en SHALL never be high in two consecutive cycles; the minimum read interval is 3 cycles (IDLE, REQ, CAPTURE), which guards against the lagging empty flag.
REQ-019 Buffer SHALL be a 2-entry in-order queue; at most one read in flight, so a capture always has space.
REQ-020 m_valid = (occupancy != 0); m_q0..7 = head entry; head SHALL be stable while m_valid=1 and m_ready=0.
REQ-021 Pop on m_valid & m_ready; simultaneous capture and pop SHALL leave occupancy unchanged and keep order.
REQ-022 m_ready while m_valid=0 SHALL have no effect.
REQ-023 pair_count SHALL increment by 1 per pop, wrapping 0xFFFF->0x0000.
REQ-024 Deasserting enable in REQ or CAPTURE SHALL NOT abort; the entry is still captured.
REQ-025 First entry latency: read strobe in cycle N, m_valid high in cycle N+2.

Reset
REQ-026 On reset: state IDLE, fifo_read_en=0, occupancy 0, m_valid=0, m_q0..7=0, pair_count=0, busy=0.
REQ-027 Reset mid-REQ or mid-CAPTURE SHALL discard in-flight and buffered data; the next cycle is IDLE with all outputs at reset values.

Structure
REQ-028 Shared package quat_pkg SHALL hold DATA_W, LANES and the reader FSM state encoding.
REQ-029 The 2-entry queue SHALL be a sub-module quat_skid_buf, parameterised by DATA_W and LANES.

Verification
REQ-030 Reset, then FIFO not empty with entry lanes 0x0001..0x0008, m_ready=1 -> read_en pulse in cycle 1, m_valid in cycle 3 with m_q0..7=0x0001..0x0008, pair_count=1.
REQ-031 4 entries queued, m_ready=0 -> exactly 2 read pulses, m_valid held, head unchanged, no further read_en; m_ready=1 -> remaining 2 drained in order, pair_count=4.
REQ-032 fifo_empty toggling every cycle with continuous m_ready=1 -> read_en never high in consecutive cycles, no read issued while fifo_empty=1.
REQ-033 enable dropped in REQ -> entry still captured and delivered, no later read_en until enable=1.
REQ-034 Reset asserted in CAPTURE with one entry buffered -> next cycle m_valid=0, pair_count=0, fifo_read_en=0.
REQ-035 pair_count preset path: 65536 transfers -> pair_count wraps to 0x0000.
